// File: rtl/hilo_div_ctrl_pkg.sv
// Shared state encodings and control constants for the HI/LO divide sequencer.
package hilo_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic RST_ENABLE           = 1'b0;

endpackage

// File: rtl/hilo_div_ctrl_if.sv
// Execute-stage <-> divide sequencer handshake and result bus.
interface hilo_div_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] opdata1_i;
  logic [WIDTH-1:0] opdata2_i;
  logic             annul_i;
  logic             stallreq_o;
  logic             ready_o;
  logic             hilo_we_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    input  stallreq_o, ready_o, hilo_we_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, opdata1_i, opdata2_i, annul_i,
    output stallreq_o, ready_o, hilo_we_o, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_div_ctrl_div_step.sv
// One radix-2 restoring iteration: shift {rem, quo} left, trial-subtract the divisor.
module hilo_div_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] work_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] work_out
);

  logic [2*WIDTH:0] shifted;
  logic [WIDTH+1:0] diff;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = work_in << 1;
    // One extra guard bit turns the borrow into a plain sign test.
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};
    if (!diff[WIDTH+1]) begin
      work_out = {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      work_out = shifted;
    end
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: stalls execute, then strobes quotient to LO, remainder to HI.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  hilo_div_ctrl_if.slave bus
);

  localparam int             CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  div_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] work;
  logic [2*WIDTH:0] work_next;
  logic [WIDTH-1:0] divisor;
  logic             quo_neg;
  logic             rem_neg;
  logic             ready;
  logic             hilo_we;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_mag;
  logic [WIDTH-1:0] op2_mag;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    op1_neg = bus.signed_i & bus.opdata1_i[WIDTH-1];
    op2_neg = bus.signed_i & bus.opdata2_i[WIDTH-1];
    op1_mag = op1_neg ? neg(bus.opdata1_i) : bus.opdata1_i;
    op2_mag = op2_neg ? neg(bus.opdata2_i) : bus.opdata2_i;
    quo_fix = quo_neg ? neg(work[WIDTH-1:0]) : work[WIDTH-1:0];
    rem_fix = rem_neg ? neg(work[2*WIDTH-1:WIDTH]) : work[2*WIDTH-1:WIDTH];
  end

  hilo_div_ctrl_div_step #(.WIDTH(WIDTH)) u_div_step (
    .work_in  (work),
    .divisor  (divisor),
    .work_out (work_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state   <= DIV_FREE;
      cnt     <= '0;
      work    <= '0;
      divisor <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      ready   <= DIV_RESULT_NOT_READY;
      hilo_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      hilo_we <= 1'b0;
      case (state)
        DIV_FREE: begin
          if (bus.start_i == DIV_START && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state   <= DIV_ON;
              cnt     <= '0;
              work    <= {{(WIDTH+1){1'b0}}, op1_mag};
              divisor <= op2_mag;
              quo_neg <= op1_neg ^ op2_neg;
              rem_neg <= op1_neg;
            end
          end
        end

        DIV_BY_ZERO: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
          end else begin
            state   <= DIV_END;
            hi      <= '0;
            lo      <= '0;
            ready   <= DIV_RESULT_READY;
            hilo_we <= 1'b1;
          end
        end

        DIV_ON: begin
          if (bus.annul_i) begin
            state <= DIV_FREE;
            cnt   <= '0;
          end else if (cnt != LAST_CNT) begin
            work <= work_next;
            cnt  <= cnt + CNT_W'(1);
          end else begin
            state   <= DIV_END;
            cnt     <= '0;
            hi      <= rem_fix;
            lo      <= quo_fix;
            ready   <= DIV_RESULT_READY;
            hilo_we <= 1'b1;
          end
        end

        DIV_END: begin
          // A held start only keeps the result visible; a new divide needs start to drop first.
          if (bus.annul_i || bus.start_i == DIV_STOP) begin
            state <= DIV_FREE;
            ready <= DIV_RESULT_NOT_READY;
            hi    <= '0;
            lo    <= '0;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

  assign bus.ready_o    = ready;
  assign bus.hilo_we_o  = hilo_we;
  assign bus.hi_o       = hi;
  assign bus.lo_o       = lo;
  assign bus.stallreq_o = bus.start_i & ~ready & ~bus.annul_i;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed, table-driven bench for the HI/LO divide sequencer.
module tb_hilo_div_ctrl;

  localparam int WIDTH  = 32;
  localparam int ON_LAT = WIDTH + 1;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   we_count;

  hilo_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

  hilo_div_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.hilo_we_o) we_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.signed_i  = v.sgn;
    bus.opdata1_i = v.a;
    bus.opdata2_i = v.b;
    bus.annul_i   = 1'b0;
  endtask

  // Returns edges after the sampling edge until ready, and how many samples saw a stall.
  task automatic wait_ready(output int lat, output int stall_hi);
    lat      = 0;
    stall_hi = 0;
    @(posedge clk); #1;
    if (bus.stallreq_o) stall_hi++;
    while (!bus.ready_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (!bus.ready_o && bus.stallreq_o) stall_hi++;
    end
  endtask

  task automatic complete(input vec_t v, input string tag);
    int lat, stall_hi, we0, exp_lat;
    we0     = we_count;
    exp_lat = (v.b == 0) ? 1 : ON_LAT;
    wait_ready(lat, stall_hi);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_stall_cycles"}, stall_hi, exp_lat);
    check({tag, "_lo"}, bus.lo_o, v.lo);
    check({tag, "_hi"}, bus.hi_o, v.hi);
    check({tag, "_we"}, bus.hilo_we_o, 1);
    check({tag, "_stall_at_ready"}, bus.stallreq_o, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_we_held"}, bus.hilo_we_o, 0);
    check({tag, "_ready_held"}, bus.ready_o, 1);
    check({tag, "_lo_held"}, bus.lo_o, v.lo);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ready_clr"}, bus.ready_o, 0);
    check({tag, "_lo_clr"}, bus.lo_o, 0);
    check({tag, "_hi_clr"}, bus.hi_o, 0);
    check({tag, "_strobes"}, we_count - we0, 1);
  endtask

  vec_t vecs[13];

  initial begin
    int   we0, lat, stall_hi;
    vec_t v;

    vecs[0]  = '{1'b0, 32'd100,      32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF};
    vecs[2]  = '{1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1};
    vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[4]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[5]  = '{1'b0, 32'd5,        32'd0,          32'd0,          32'd0};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'h10,         32'h0FFFFFFF,   32'hF};
    vecs[8]  = '{1'b1, 32'hFFFFFF9C, 32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[9]  = '{1'b1, 32'd3,        32'd10,         32'd0,          32'd3};
    vecs[10] = '{1'b0, 32'hFFFFFFFF, 32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'd0,          32'd0,          32'd0};
    vecs[12] = '{1'b0, 32'd1000000,  32'd1000,       32'd1000,       32'd0};

    total         = 0;
    bad           = 0;
    we_count      = 0;
    rst           = 1'b0;
    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", bus.ready_o, 0);
    check("reset_we", bus.hilo_we_o, 0);
    check("reset_hi", bus.hi_o, 0);
    check("reset_lo", bus.lo_o, 0);
    check("reset_stall", bus.stallreq_o, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      complete(vecs[i], $sformatf("vec%0d", i));
    end

    // Annul ten cycles into a divide, then a fresh divide must run at full latency.
    we0 = we_count;
    drive(vecs[0]);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    #1;
    check("annul_on_stall", bus.stallreq_o, 0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_on_ready", bus.ready_o, 0);
    check("annul_on_strobes", we_count - we0, 0);
    v = '{1'b0, 32'd1000, 32'd3, 32'd333, 32'd1};
    drive(v);
    complete(v, "after_annul");

    // Start and annul together in IDLE must not launch a divide.
    we0 = we_count;
    drive(vecs[0]);
    bus.annul_i = 1'b1;
    #1;
    check("annul_idle_stall", bus.stallreq_o, 0);
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("annul_idle_strobes", we_count - we0, 0);
    check("annul_idle_ready", bus.ready_o, 0);

    // Annul while parked in END with start still held.
    we0 = we_count;
    drive(vecs[0]);
    wait_ready(lat, stall_hi);
    check("annul_end_lo", bus.lo_o, 32'd14);
    @(negedge clk);
    bus.annul_i = 1'b1;
    #1;
    check("annul_end_stall", bus.stallreq_o, 0);
    @(posedge clk); #1;
    check("annul_end_ready", bus.ready_o, 0);
    check("annul_end_lo_clr", bus.lo_o, 0);
    check("annul_end_we", bus.hilo_we_o, 0);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("annul_end_strobes", we_count - we0, 1);

    // Asynchronous reset between edges during ON; start stays held across release.
    v = '{1'b1, 32'h7FFFFFFF, 32'd3, 32'h2AAAAAAA, 32'd1};
    drive(v);
    repeat (6) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_on_ready", bus.ready_o, 0);
    check("rst_on_we", bus.hilo_we_o, 0);
    check("rst_on_stall", bus.stallreq_o, 1);
    @(negedge clk);
    rst = 1'b1;
    complete(v, "after_rst_on");

    // Asynchronous reset in the first END cycle clears the strobe and result at once.
    drive(vecs[7]);
    wait_ready(lat, stall_hi);
    check("rst_end_we_pre", bus.hilo_we_o, 1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_end_we", bus.hilo_we_o, 0);
    check("rst_end_ready", bus.ready_o, 0);
    check("rst_end_lo", bus.lo_o, 0);
    check("rst_end_hi", bus.hi_o, 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_end_idle", bus.ready_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
